// File: rtl/phys_free_list_pkg.sv
// Shared constants, pointer/preg types and checkpoint record for the physical-register free list.
`default_nettype none
package phys_free_list_pkg;
  localparam int PHYS_REGS = 64;
  localparam int ARCH_REGS = 32;
  localparam int COB_DEPTH = 4;
  localparam int PREG_W    = $clog2(PHYS_REGS);
  localparam int DEPTH     = PHYS_REGS - ARCH_REGS;
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int PTR_W     = IDX_W + 1;
  localparam int TAG_W     = $clog2(COB_DEPTH);

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PTR_W-1:0]  fl_ptr_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [PREG_W:0]   fl_cnt_t;

  typedef struct packed {
    logic    valid;
    fl_ptr_t head;
  } fl_ckpt_t;

  // Wrap-bit pointers make tail-head the occupancy directly, including the full case.
  function automatic fl_cnt_t fl_count(input fl_ptr_t tail, input fl_ptr_t head);
    fl_ptr_t diff;
    diff = tail - head;
    return fl_cnt_t'(diff);
  endfunction
endpackage
`default_nettype wire

// File: rtl/phys_free_list_if.sv
// Rename/commit/branch-unit interface of the physical-register free list.
`default_nettype none
interface phys_free_list_if;
  import phys_free_list_pkg::*;

  logic    ren;
  preg_t   rdata;
  logic    empty;
  logic    wen;
  preg_t   wdata;
  logic    ckpt_we;
  tag_t    ckpt_tag;
  logic    br_broadcast;
  logic    br_kill;
  logic    br_clean;
  tag_t    br_tag;
  fl_cnt_t count;

  modport master (
    output ren, wen, wdata, ckpt_we, ckpt_tag, br_broadcast, br_kill, br_clean, br_tag,
    input  rdata, empty, count
  );
  modport slave (
    input  ren, wen, wdata, ckpt_we, ckpt_tag, br_broadcast, br_kill, br_clean, br_tag,
    output rdata, empty, count
  );
endinterface
`default_nettype wire

// File: rtl/phys_free_list_ckpt.sv
// Branch checkpoint table: saved head pointers plus an age matrix so a kill also drops younger slots.
`default_nettype none
module free_list_ckpt
  import phys_free_list_pkg::*;
(
  input  wire logic    clk,
  input  wire logic    rst_n,
  input  wire logic    i_wr_en,
  input  wire tag_t    i_wr_tag,
  input  wire fl_ptr_t i_wr_head,
  input  wire logic    i_clean_en,
  input  wire logic    i_kill_en,
  input  wire tag_t    i_br_tag,
  output logic         o_restore_valid,
  output fl_ptr_t      o_restore_head
);
  fl_ckpt_t                r_slot    [COB_DEPTH];
  // r_younger[i][j] set means slot j was taken while slot i was live.
  logic [COB_DEPTH-1:0]    r_younger [COB_DEPTH];

  assign o_restore_valid = r_slot[i_br_tag].valid;
  assign o_restore_head  = r_slot[i_br_tag].head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < COB_DEPTH; i++) begin
        r_slot[i]    <= '0;
        r_younger[i] <= '0;
      end
    end else if (i_kill_en && r_slot[i_br_tag].valid) begin
      for (int j = 0; j < COB_DEPTH; j++) begin
        if ((TAG_W'(j) == i_br_tag) || r_younger[i_br_tag][j]) begin
          r_slot[j].valid <= 1'b0;
        end
      end
    end else begin
      if (i_clean_en) begin
        r_slot[i_br_tag].valid <= 1'b0;
      end
      if (i_wr_en) begin
        r_slot[i_wr_tag]    <= '{valid: 1'b1, head: i_wr_head};
        r_younger[i_wr_tag] <= '0;
        for (int j = 0; j < COB_DEPTH; j++) begin
          if (TAG_W'(j) != i_wr_tag) begin
            r_younger[j][i_wr_tag] <= r_slot[j].valid;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(i_kill_en && !r_slot[i_br_tag].valid))
        else $error("free_list_ckpt: kill of invalid checkpoint slot %0d", i_br_tag);
    end
  end
endmodule
`default_nettype wire

// File: rtl/phys_free_list.sv
// Circular free list of physical registers with head checkpoint/restore for branch recovery.
// Optional FREE_LIST_BYPASS_EN forwards a freed preg straight to rename when the list is empty.
`default_nettype none
module phys_free_list
  import phys_free_list_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst_n,
  phys_free_list_if.slave  fl
);
  preg_t   r_mem [DEPTH];
  fl_ptr_t r_head;
  fl_ptr_t r_tail;

  fl_cnt_t w_count;
  logic    w_empty_reg;
  logic    w_full;
  logic    w_kill;
  logic    w_clean;
  logic    w_bypass;
  logic    w_pop;
  logic    w_push;
  fl_ptr_t w_head_pop;
  logic    w_restore_valid;
  fl_ptr_t w_restore_head;

  assign w_count     = fl_count(r_tail, r_head);
  assign w_empty_reg = (w_count == '0);
  assign w_full      = (w_count == fl_cnt_t'(DEPTH));
  assign w_kill      = fl.br_broadcast & fl.br_kill;
  assign w_clean     = fl.br_broadcast & fl.br_clean & ~w_kill;

`ifdef FREE_LIST_BYPASS_EN
  assign w_bypass = w_empty_reg & fl.wen & fl.ren & ~w_kill;
`else
  assign w_bypass = 1'b0;
`endif

  // Rename is flushed on a kill, so its pop that cycle must not move head.
  assign w_pop      = fl.ren & ~w_kill & (~w_empty_reg | w_bypass);
  assign w_push     = fl.wen & ~w_full;
  assign w_head_pop = r_head + fl_ptr_t'(w_pop);

  assign fl.rdata = w_bypass ? fl.wdata : r_mem[r_head[IDX_W-1:0]];
  assign fl.empty = w_empty_reg & ~w_bypass;
  assign fl.count = w_count;

  free_list_ckpt u_ckpt (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_wr_en         (fl.ckpt_we & ~w_kill),
    .i_wr_tag        (fl.ckpt_tag),
    .i_wr_head       (w_head_pop),
    .i_clean_en      (w_clean),
    .i_kill_en       (w_kill),
    .i_br_tag        (fl.br_tag),
    .o_restore_valid (w_restore_valid),
    .o_restore_head  (w_restore_head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= preg_t'(ARCH_REGS + i);
      end
      r_head <= '0;
      r_tail <= fl_ptr_t'(DEPTH);
    end else begin
      if (w_push) begin
        r_mem[r_tail[IDX_W-1:0]] <= fl.wdata;
        r_tail                   <= r_tail + 1'b1;
      end
      if (w_kill) begin
        if (w_restore_valid) begin
          r_head <= w_restore_head;
        end
      end else begin
        r_head <= w_head_pop;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(fl.wen && w_full))
        else $error("phys_free_list: free of preg %0d while list full, dropped", fl.wdata);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_phys_free_list.sv
// Directed and randomised checks of phys_free_list against hand values and a queue-based model.
`default_nettype none
module tb_phys_free_list;
  import phys_free_list_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  phys_free_list_if fl ();
  phys_free_list dut (.clk(clk), .rst_n(rst_n), .fl(fl));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    fl.ren = 1'b0; fl.wen = 1'b0; fl.wdata = '0;
    fl.ckpt_we = 1'b0; fl.ckpt_tag = '0;
    fl.br_broadcast = 1'b0; fl.br_kill = 1'b0; fl.br_clean = 1'b0; fl.br_tag = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic kill(input int tag);
    fl.br_broadcast = 1'b1; fl.br_kill = 1'b1; fl.br_tag = tag_t'(tag);
  endtask

  // Model state: unwrapped integer pointers and an age-ordered list of live checkpoint tags.
  int m_mem [DEPTH];
  int m_head, m_tail;
  int m_ck [COB_DEPTH];
  int ckq [$];

  function automatic int q_find(input int t);
    for (int i = 0; i < ckq.size(); i++) if (ckq[i] == t) return i;
    return -1;
  endfunction

  initial begin
    int k, cnt, minh, exp, pop, bypass, push, hp;
    int free_tags [$];
    rst_n = 1'b0;
    idle();

    // Reset state and drain
    do_reset();
    #1;
    check("rst_empty", 32'(fl.empty), 0);
    check("rst_rdata", 32'(fl.rdata), 32);
    check("rst_count", 32'(fl.count), 32);
    fl.ren = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1 check($sformatf("drain%0d", i), 32'(fl.rdata), 32'(32 + i));
      tick();
    end
    fl.ren = 1'b0;
    #1;
    check("drain_empty", 32'(fl.empty), 1);
    check("drain_count", 32'(fl.count), 0);
    fl.ren = 1'b1;
    tick();
    fl.ren = 1'b0;
    #1 check("pop_empty_ignored", 32'(fl.count), 0);

    // Free while empty together with a pop
    fl.wen = 1'b1; fl.wdata = 6'd5; fl.ren = 1'b1;
`ifdef FREE_LIST_BYPASS_EN
    #1;
    check("byp_rdata", 32'(fl.rdata), 5);
    check("byp_empty", 32'(fl.empty), 0);
    tick();
    idle();
    #1;
    check("byp_count", 32'(fl.count), 0);
    check("byp_empty_after", 32'(fl.empty), 1);
`else
    tick();
    idle();
    #1;
    check("nobyp_count", 32'(fl.count), 1);
    check("nobyp_rdata", 32'(fl.rdata), 5);
    fl.ren = 1'b1;
    tick();
    idle();
    #1 check("nobyp_empty_after", 32'(fl.empty), 1);
`endif

    // Checkpoint with pop, then kill restores just past the branch's own preg
    do_reset();
    fl.ren = 1'b1;
    tick(); tick(); tick();
    fl.ckpt_we = 1'b1; fl.ckpt_tag = 2'd1;
    #1 check("ckpt_rdata", 32'(fl.rdata), 35);
    tick();
    fl.ckpt_we = 1'b0;
    tick(); tick();
    fl.ckpt_we = 1'b1; fl.ckpt_tag = 2'd0;
    kill(1);
    tick();
    idle();
    #1;
    check("kill_rdata", 32'(fl.rdata), 36);
    check("kill_count", 32'(fl.count), 28);

    // Nested checkpoints: kill of the older one, then clean leaves head alone
    do_reset();
    fl.ckpt_we = 1'b1; fl.ckpt_tag = 2'd0;
    tick();
    fl.ckpt_we = 1'b0; fl.ren = 1'b1;
    tick(); tick();
    fl.ren = 1'b0; fl.ckpt_we = 1'b1; fl.ckpt_tag = 2'd2;
    tick();
    fl.ckpt_we = 1'b0; fl.ren = 1'b1;
    tick();
    fl.ren = 1'b0;
    kill(0);
    tick();
    idle();
    #1;
    check("nest_rdata", 32'(fl.rdata), 32);
    check("nest_count", 32'(fl.count), 32);
    fl.ckpt_we = 1'b1; fl.ckpt_tag = 2'd3;
    tick();
    fl.ckpt_we = 1'b0; fl.ren = 1'b1;
    tick(); tick();
    fl.ren = 1'b0;
    fl.br_broadcast = 1'b1; fl.br_clean = 1'b1; fl.br_tag = 2'd3;
    tick();
    idle();
    #1;
    check("clean_rdata", 32'(fl.rdata), 34);
    check("clean_count", 32'(fl.count), 30);

    // Kill with a same-cycle free: tail still advances
    do_reset();
    fl.ren = 1'b1;
    tick(); tick();
    fl.ren = 1'b0; fl.ckpt_we = 1'b1; fl.ckpt_tag = 2'd3;
    tick();
    fl.ckpt_we = 1'b0; fl.ren = 1'b1;
    tick();
    fl.ren = 1'b0;
    kill(3);
    fl.wen = 1'b1; fl.wdata = 6'd40;
    tick();
    idle();
    #1;
    check("killw_rdata", 32'(fl.rdata), 34);
    check("killw_count", 32'(fl.count), 31);
    fl.ren = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    fl.ren = 1'b0;
    #1;
    check("wrap_rdata", 32'(fl.rdata), 40);
    check("wrap_count", 32'(fl.count), 1);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = ARCH_REGS + i;
    m_head = 0; m_tail = DEPTH;
    ckq.delete();
    for (int c = 0; c < 1000; c++) begin
      idle();
      cnt  = m_tail - m_head;
      minh = (ckq.size() > 0) ? m_ck[ckq[0]] : m_head;
      fl.ren   = ($urandom_range(0, 99) < 55);
      fl.wen   = ((m_tail - minh) < DEPTH) && ($urandom_range(0, 99) < 45);
      fl.wdata = preg_t'($urandom_range(0, 63));
      if (ckq.size() > 0 && $urandom_range(0, 99) < 6) begin
        fl.br_broadcast = 1'b1; fl.br_kill = 1'b1;
        fl.br_tag = tag_t'(ckq[$urandom_range(0, ckq.size() - 1)]);
      end else if (ckq.size() > 0 && $urandom_range(0, 99) < 6) begin
        fl.br_broadcast = 1'b1; fl.br_clean = 1'b1;
        fl.br_tag = tag_t'(ckq[$urandom_range(0, ckq.size() - 1)]);
      end
      free_tags.delete();
      for (int t = 0; t < COB_DEPTH; t++) if (q_find(t) < 0) free_tags.push_back(t);
      if (free_tags.size() > 0 && $urandom_range(0, 99) < 12) begin
        fl.ckpt_we  = 1'b1;
        fl.ckpt_tag = tag_t'(free_tags[$urandom_range(0, free_tags.size() - 1)]);
      end

      bypass = 0;
`ifdef FREE_LIST_BYPASS_EN
      bypass = (cnt == 0 && fl.wen && fl.ren && !fl.br_kill) ? 1 : 0;
`endif
      pop  = (fl.ren && !fl.br_kill && (cnt != 0 || bypass != 0)) ? 1 : 0;
      push = (fl.wen && cnt != DEPTH) ? 1 : 0;
      if (bypass != 0) exp = (0 << 13) | (cnt << 6) | int'(fl.wdata);
      else exp = ((cnt == 0 ? 1 : 0) << 13) | (cnt << 6) | m_mem[m_head % DEPTH];
      #1 check("rand", 32'({fl.empty, fl.count, fl.rdata}), 32'(exp));

      if (push != 0) begin
        m_mem[m_tail % DEPTH] = int'(fl.wdata);
        m_tail++;
      end
      hp = m_head + pop;
      if (fl.br_kill) begin
        k = q_find(int'(fl.br_tag));
        if (k >= 0) begin
          m_head = m_ck[fl.br_tag];
          while (ckq.size() > k) ckq.delete(k);
        end
      end else begin
        m_head = hp;
        if (fl.br_clean) begin
          k = q_find(int'(fl.br_tag));
          if (k >= 0) ckq.delete(k);
        end
        if (fl.ckpt_we) begin
          k = q_find(int'(fl.ckpt_tag));
          if (k >= 0) ckq.delete(k);
          ckq.push_back(int'(fl.ckpt_tag));
          m_ck[fl.ckpt_tag] = hp;
        end
      end
      tick();
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
